// File: rtl/rf_scoreboard_pkg.sv
// Shared register-file sizing constants.
// Used by the scoreboard and the bypassing register file.
package rf_scoreboard_pkg;

    localparam int RF_NUM_REGS = 8;
    localparam int RF_SEL_W    = 3;
    localparam int RF_CNT_W    = 2;

    // Largest in-flight count a register can hold before issue stalls.
    function automatic int rfCntMax(input int cntW);
        return (1 << cntW) - 1;
    endfunction

endpackage

// File: rtl/rf_sb_counter.sv
// Per-register in-flight write counter.
// Saturates at both ends; flags a retire with nothing outstanding.
module rf_sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = RF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] cntMax = CNT_W'(rfCntMax(CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && count != cntMax) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign nonzero   = |count;
    assign underflow = dec && !inc && (count == '0);

endmodule

// File: rtl/rf_scoreboard.sv
// Write-side hazard tracker for the register file.
// Stalls decode while a source still has an older write in flight.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int SEL_W    = RF_SEL_W,
    parameter int CNT_W    = RF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issueEn,
    input  logic [SEL_W-1:0]    issueRegSel,
    input  logic                read1En,
    input  logic [SEL_W-1:0]    readReg1Sel,
    input  logic                read2En,
    input  logic [SEL_W-1:0]    readReg2Sel,
    input  logic                wbEn,
    input  logic [SEL_W-1:0]    wbRegSel,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                err
);

    localparam logic [CNT_W-1:0] cntMax = CNT_W'(rfCntMax(CNT_W));

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    logic [NUM_REGS-1:0] unf;
    logic [NUM_REGS-1:0] wbHit;
    logic [NUM_REGS-1:0] pendVec;
    logic [NUM_REGS-1:0] incVec;
    logic                full;
    logic                issueAcc;

    // A write retiring this cycle is forwarded by the bypass, so it
    // no longer counts as pending when it is the last one.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wbHit[r]   = wbEn && (wbRegSel == SEL_W'(r));
            pendVec[r] = nz[r] && !(wbHit[r] && cnt[r] == CNT_W'(1));
        end
    end

    assign full = (cnt[issueRegSel] == cntMax) && !wbHit[issueRegSel];

    assign stall = (read1En && pendVec[readReg1Sel])
                || (read2En && pendVec[readReg2Sel])
                || (issueEn && full);

    assign issueAcc = issueEn && !stall;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            incVec[r] = issueAcc && (issueRegSel == SEL_W'(r));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gCnt
        rf_sb_counter #(
            .CNT_W(CNT_W)
        ) uCnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (incVec[g]),
            .dec      (wbHit[g]),
            .count    (cnt[g]),
            .nonzero  (nz[g]),
            .underflow(unf[g])
        );
    end

    assign busy = nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (|unf) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard.
// Reference counter model feeds an expected-value queue.
module tb_rf_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issueEn = 1'b0;
    logic [2:0] issueRegSel = '0;
    logic       read1En = 1'b0;
    logic [2:0] readReg1Sel = '0;
    logic       read2En = 1'b0;
    logic [2:0] readReg2Sel = '0;
    logic       wbEn = 1'b0;
    logic [2:0] wbRegSel = '0;
    logic       stall;
    logic [7:0] busy;
    logic       err;

    int nChecks = 0;
    int nErrors = 0;

    int  mc [8];
    bit  mErr;
    logic [15:0] expQ [$];

    always #5 clk = ~clk;

    rf_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issueEn    (issueEn),
        .issueRegSel(issueRegSel),
        .read1En    (read1En),
        .readReg1Sel(readReg1Sel),
        .read2En    (read2En),
        .readReg2Sel(readReg2Sel),
        .wbEn       (wbEn),
        .wbRegSel   (wbRegSel),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    function automatic bit mPend(int s);
        return (mc[s] != 0) &&
               !(wbEn && int'(wbRegSel) == s && mc[s] == 1);
    endfunction

    function automatic bit mStall();
        bit full;
        full = (mc[issueRegSel] == 3) &&
               !(wbEn && wbRegSel == issueRegSel);
        return (read1En && mPend(int'(readReg1Sel))) ||
               (read2En && mPend(int'(readReg2Sel))) ||
               (issueEn && full);
    endfunction

    function automatic logic [7:0] mBusy();
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = (mc[r] != 0);
        return b;
    endfunction

    task automatic mReset();
        for (int r = 0; r < 8; r++) mc[r] = 0;
        mErr = 1'b0;
    endtask

    // One cycle: drive at negedge, check stall, then post-edge state.
    task automatic step(input bit ie, input int is, input bit r1e,
                        input int r1, input bit r2e, input int r2,
                        input bit we, input int ws);
        bit acc, inc, dec;
        @(negedge clk);
        issueEn = ie; issueRegSel = 3'(is);
        read1En = r1e; readReg1Sel = 3'(r1);
        read2En = r2e; readReg2Sel = 3'(r2);
        wbEn = we; wbRegSel = 3'(ws);
        expQ.push_back(16'(mStall()));
        #1;
        chk("stall", 16'(stall), expQ.pop_front());
        acc = ie && !mStall();
        for (int r = 0; r < 8; r++) begin
            inc = acc && is == r;
            dec = we && ws == r;
            if (inc && !dec && mc[r] < 3) mc[r]++;
            else if (dec && !inc) begin
                if (mc[r] == 0) mErr = 1'b1;
                else mc[r]--;
            end
        end
        @(posedge clk);
        expQ.push_back(16'(mBusy()));
        expQ.push_back(16'(mErr));
        #1;
        chk("busy", 16'(busy), expQ.pop_front());
        chk("err", 16'(err), expQ.pop_front());
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        mReset();
        #12 rst_n = 1'b1;

        // RAW hazard on r3, released by same-cycle writeback
        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 0, 0);
        step(0, 0, 1, 3, 0, 0, 1, 3);
        idle();

        // Three writers to r5, then a fourth at the limit
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0, 0, 1, 5);
        step(0, 0, 1, 5, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0, 1, 5);

        // Issue and retire r2 together, reader not stalled
        step(1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 2, 1, 2, 0, 0, 1, 2);
        step(0, 0, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2);

        // Underflow on r6, r1 keeps tracking
        step(0, 0, 0, 0, 0, 0, 1, 6);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 1);
        step(0, 0, 1, 6, 0, 0, 0, 0);

        // Stalled issue to r4 leaves r4 untouched
        step(1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 4, 1, 7, 0, 0, 0, 0);
        step(1, 4, 0, 0, 1, 7, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7);
        step(0, 0, 0, 0, 0, 0, 1, 4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
        end

        // Make sure state is non-trivial, then reset mid-cycle
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        mReset();
        #1;
        chk("rst_busy", 16'(busy), 16'h00);
        chk("rst_err", 16'(err), 16'(0));
        issueEn = 1'b0; read2En = 1'b0; wbEn = 1'b0;
        read1En = 1'b1;
        for (int r = 0; r < 8; r++) begin
            readReg1Sel = 3'(r);
            #1;
            chk("rst_stall", 16'(stall), 16'(0));
        end
        read1En = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 1, 3);
        idle();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
